// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master, one-slave arbiter for the PicoRV32 native memory bus.
// Ports: clk, reset_n; m0_* (loader) and m1_* (cpu) request/response;
//   s_* slave request/response; grant (one-hot owner); timeout_err (abort pulse).
// Optional: define MEM_ARB_ROUND_ROBIN_EN for round-robin tie break;
//   default build uses fixed priority with m0 winning ties.
// TIMEOUT = 0 disables the watchdog.
module mem_arbiter #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_mem_valid,
  input  logic        m0_mem_instr,
  input  logic [31:0] m0_mem_addr,
  input  logic [31:0] m0_mem_wdata,
  input  logic [3:0]  m0_mem_wstrb,
  output logic        m0_mem_ready,
  output logic [31:0] m0_mem_rdata,
  input  logic        m1_mem_valid,
  input  logic        m1_mem_instr,
  input  logic [31:0] m1_mem_addr,
  input  logic [31:0] m1_mem_wdata,
  input  logic [3:0]  m1_mem_wstrb,
  output logic        m1_mem_ready,
  output logic [31:0] m1_mem_rdata,
  output logic        s_mem_valid,
  output logic        s_mem_instr,
  output logic [31:0] s_mem_addr,
  output logic [31:0] s_mem_wdata,
  output logic [3:0]  s_mem_wstrb,
  input  logic        s_mem_ready,
  input  logic [31:0] s_mem_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam int unsigned WW =
    (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WLIM =
    (TIMEOUT < 1) ? '0 : WW'(TIMEOUT - 1);
  localparam bit WDOG_ON = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ABORT
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [WW-1:0] wdog_q, wdog_d;

  logic own_valid;
  logic tie_pick;
  logic pick;
  logic in_grant;
  logic in_abort;

  // owner encoding: 0 = m0, 1 = m1
  assign own_valid = owner_q ? m1_mem_valid : m0_mem_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign tie_pick = ~last_q;
`else
  assign tie_pick = 1'b0;
`endif

  assign pick = (m0_mem_valid & m1_mem_valid) ? tie_pick : m1_mem_valid;

  assign in_grant = (state_q == GRANT);
  assign in_abort = (state_q == ABORT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    unique case (state_q)
      IDLE: begin
        if (m0_mem_valid | m1_mem_valid) begin
          owner_d = pick;
          state_d = GRANT;
          wdog_d  = '0;
        end
      end
      GRANT: begin
        if (!own_valid) begin
          // owner withdrew: release without a ready
          state_d = IDLE;
          wdog_d  = '0;
        end else if (s_mem_ready) begin
          state_d = IDLE;
          last_d  = owner_q;
          wdog_d  = '0;
        end else if (WDOG_ON && (wdog_q == WLIM)) begin
          state_d = ABORT;
          wdog_d  = '0;
        end else if (WDOG_ON) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ABORT: begin
        state_d = IDLE;
        last_d  = owner_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    s_mem_valid  = 1'b0;
    s_mem_instr  = 1'b0;
    s_mem_addr   = '0;
    s_mem_wdata  = '0;
    s_mem_wstrb  = '0;
    m0_mem_ready = 1'b0;
    m1_mem_ready = 1'b0;
    m0_mem_rdata = '0;
    m1_mem_rdata = '0;
    grant        = 2'b00;
    timeout_err  = 1'b0;
    unique case (1'b1)
      in_grant: begin
        grant        = owner_q ? 2'b10 : 2'b01;
        s_mem_valid  = own_valid;
        s_mem_instr  = owner_q ? m1_mem_instr : m0_mem_instr;
        s_mem_addr   = owner_q ? m1_mem_addr  : m0_mem_addr;
        s_mem_wdata  = owner_q ? m1_mem_wdata : m0_mem_wdata;
        s_mem_wstrb  = owner_q ? m1_mem_wstrb : m0_mem_wstrb;
        m0_mem_ready = ~owner_q & s_mem_ready;
        m1_mem_ready =  owner_q & s_mem_ready;
        m0_mem_rdata = s_mem_rdata;
        m1_mem_rdata = s_mem_rdata;
      end
      in_abort: begin
        grant        = owner_q ? 2'b10 : 2'b01;
        timeout_err  = 1'b1;
        m0_mem_ready = ~owner_q;
        m1_mem_ready =  owner_q;
        m0_mem_rdata = owner_q ? 32'h0 : ERR_RDATA;
        m1_mem_rdata = owner_q ? ERR_RDATA : 32'h0;
      end
      default: begin
      end
    endcase
  end

endmodule
